// File: rtl/data_write_buffer.sv
// Write-back buffer between data_cache_L1 and memory: a circular FIFO of dirty
// 256-bit blocks with write coalescing, read forwarding and a two-state drain engine.
module data_write_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         wb_req,
    input  logic [31:0]  wb_addr,
    input  logic [255:0] wb_data,
    output logic         wb_ack,
    input  logic         rd_req,
    input  logic [31:0]  rd_addr,
    output logic         rd_hit,
    output logic [255:0] rd_data,
    output logic         mem_write_req,
    output logic [31:0]  mem_write_addr,
    output logic [255:0] mem_write_data,
    input  logic         mem_write_valid,
    input  logic         flush,
    output logic         flush_done,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULLCOUNT = (PW+1)'(DEPTH);

    typedef enum logic [0:0] {IDLE, WRITE} drainStateT;

    drainStateT     state, stateNext;
    logic [DEPTH-1:0] entValid;
    logic [26:0]    entTag  [DEPTH];
    logic [255:0]   entData [DEPTH];
    logic [PW-1:0]  head, tail;
    logic [PW:0]    count;

    logic           locked, pop, isFull, accept, coalesce, enqueue;
    logic           coalHit, rdMatch;
    logic [PW-1:0]  coalIdx, rdIdx, scanIdx;
    logic           unusedInputs;

    // flush only observes the drain; it never steers it
    assign unusedInputs = ^{flush, wb_addr[4:0], rd_addr[4:0]};

    assign locked   = (state == WRITE);
    assign pop      = locked && mem_write_valid;
    assign isFull   = (count == FULLCOUNT);
    assign accept   = wb_req && (coalHit || !isFull) && !RESET;
    assign coalesce = accept && coalHit;
    assign enqueue  = accept && !coalHit;

    // Scan oldest to youngest from head so the last match wins (youngest entry)
    always_comb begin
        coalHit = 1'b0;
        coalIdx = '0;
        rdMatch = 1'b0;
        rdIdx   = '0;
        scanIdx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            scanIdx = head + i[PW-1:0];
            if (entValid[scanIdx] && entTag[scanIdx] == wb_addr[31:5]
                && !(locked && scanIdx == head)) begin
                coalHit = 1'b1;
                coalIdx = scanIdx;
            end
            if (entValid[scanIdx] && entTag[scanIdx] == rd_addr[31:5]) begin
                rdMatch = 1'b1;
                rdIdx   = scanIdx;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            entValid <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            state <= stateNext;
            if (enqueue) begin
                entValid[tail] <= 1'b1;
                tail           <= tail + 1'b1;
            end
            if (pop) begin
                entValid[head] <= 1'b0;
                head           <= head + 1'b1;
            end
            unique case ({enqueue, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (coalesce) entData[coalIdx] <= wb_data;
        if (enqueue) begin
            entTag[tail]  <= wb_addr[31:5];
            entData[tail] <= wb_data;
        end
    end

    always_comb begin
        stateNext      = state;
        mem_write_req  = 1'b0;
        mem_write_addr = '0;
        mem_write_data = '0;
        unique case (state)
            IDLE: if (count != '0) stateNext = WRITE;
            WRITE: begin
                mem_write_req  = 1'b1;
                mem_write_addr = {entTag[head], 5'b0};
                mem_write_data = entData[head];
                if (mem_write_valid) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign wb_ack     = accept;
    assign rd_hit     = rd_req && rdMatch;
    assign rd_data    = rd_hit ? entData[rdIdx] : '0;
    assign full       = isFull;
    assign empty      = (count == '0);
    assign flush_done = empty && (state == IDLE);

endmodule

// File: tb/tb_data_write_buffer.sv
// Self-checking bench for data_write_buffer: directed scenarios plus a randomized
// run against a queue-based reference model of the buffer.
module tb_data_write_buffer;

    localparam int unsigned DEPTH = 4;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         wb_req, rd_req, mem_write_valid, flush;
    logic [31:0]  wb_addr, rd_addr;
    logic [255:0] wb_data;
    logic         wb_ack, rd_hit, mem_write_req, flush_done, full, empty;
    logic [255:0] rd_data, mem_write_data;
    logic [31:0]  mem_write_addr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [26:0]  tag;
        logic [255:0] data;
    } entryT;

    data_write_buffer #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ack(wb_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data),
        .mem_write_req(mem_write_req), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .mem_write_valid(mem_write_valid),
        .flush(flush), .flush_done(flush_done), .full(full), .empty(empty)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clearInputs();
        wb_req = 1'b0; wb_addr = '0; wb_data = '0;
        rd_req = 1'b0; rd_addr = '0;
        mem_write_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        wb_req = 1'b1; wb_addr = 32'h0000_4000; wb_data = rand256();
        rd_req = 1'b1; rd_addr = 32'h0000_4000;
        mem_write_valid = 1'b1; flush = 1'b1;
        @(negedge CLK);
        checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL reset_wb_ack: got %b expected 0", wb_ack); end
        checks++; if (rd_hit !== 1'b0) begin errors++; $display("FAIL reset_rd_hit: got %b expected 0", rd_hit); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (flush_done !== 1'b1) begin errors++; $display("FAIL reset_flush_done: got %b expected 1", flush_done); end
        checks++; if (mem_write_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_write_req); end
        checks++; if (mem_write_addr !== '0 || mem_write_data !== '0) begin errors++; $display("FAIL reset_mem_bus: got addr %h data %h expected 0", mem_write_addr, mem_write_data); end
        tick();
        RESET = 1'b0;
        clearInputs();
        tick();
    endtask

    task automatic test_single_block();
        logic [255:0] a = rand256();
        int n = 0;
        wb_req = 1'b1; wb_addr = 32'h1000_0024; wb_data = a;
        @(negedge CLK);
        checks++; if (wb_ack !== 1'b1) begin errors++; $display("FAIL single_ack: got %b expected 1", wb_ack); end
        tick();
        wb_req = 1'b0;
        @(negedge CLK);
        while (mem_write_req !== 1'b1 && n < 4) begin @(negedge CLK); n++; end
        checks++; if (mem_write_req !== 1'b1 || n > 1) begin errors++; $display("FAIL single_req_rise: got req %b after %0d cycles expected 1 within 1", mem_write_req, n); end
        for (int k = 1; k <= 3; k++) begin
            checks++; if (mem_write_req !== 1'b1) begin errors++; $display("FAIL single_req_hold%0d: got %b expected 1", k, mem_write_req); end
            checks++; if (mem_write_addr !== 32'h1000_0020) begin errors++; $display("FAIL single_addr%0d: got %h expected 10000020", k, mem_write_addr); end
            checks++; if (mem_write_data !== a) begin errors++; $display("FAIL single_data%0d: got %h expected %h", k, mem_write_data, a); end
            if (k == 3) mem_write_valid = 1'b1;
            tick();
            mem_write_valid = 1'b0;
            @(negedge CLK);
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b expected 1", empty); end
        checks++; if (mem_write_req !== 1'b0 || mem_write_addr !== '0) begin errors++; $display("FAIL single_idle_bus: got req %b addr %h expected 0", mem_write_req, mem_write_addr); end
        tick();
    endtask

    task automatic test_full();
        logic [26:0]  tags [5];
        logic [255:0] blks [5];
        logic [26:0]  base = 27'($urandom);
        int n;
        for (int i = 0; i < 5; i++) begin
            tags[i] = base + 27'(i);
            blks[i] = rand256();
        end
        for (int i = 0; i < 4; i++) begin
            wb_req = 1'b1; wb_addr = {tags[i], 5'($urandom)}; wb_data = blks[i];
            @(negedge CLK);
            checks++; if (wb_ack !== 1'b1) begin errors++; $display("FAIL full_ack%0d: got %b expected 1", i, wb_ack); end
            tick();
        end
        wb_addr = {tags[4], 5'b0}; wb_data = blks[4];
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            checks++; if (full !== 1'b1 || wb_ack !== 1'b0) begin errors++; $display("FAIL full_hold%0d: got full %b ack %b expected 1 0", k, full, wb_ack); end
            tick();
        end
        @(negedge CLK);
        checks++; if (mem_write_req !== 1'b1 || mem_write_addr !== {tags[0], 5'b0}) begin errors++; $display("FAIL full_head: got req %b addr %h expected 1 %h", mem_write_req, mem_write_addr, {tags[0], 5'b0}); end
        mem_write_valid = 1'b1;
        #1;
        checks++; if (wb_ack !== 1'b0) begin errors++; $display("FAIL full_pop_cycle_ack: got %b expected 0", wb_ack); end
        tick();
        mem_write_valid = 1'b0;
        @(negedge CLK);
        checks++; if (wb_ack !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL full_fifth_accept: got ack %b full %b expected 1 0", wb_ack, full); end
        tick();
        wb_req = 1'b0;
        for (int j = 1; j < 5; j++) begin
            n = 0;
            @(negedge CLK);
            while (mem_write_req !== 1'b1 && n < 8) begin @(negedge CLK); n++; end
            checks++; if (mem_write_req !== 1'b1 || mem_write_addr !== {tags[j], 5'b0} || mem_write_data !== blks[j]) begin errors++; $display("FAIL full_drain%0d: got req %b addr %h expected 1 %h", j, mem_write_req, mem_write_addr, {tags[j], 5'b0}); end
            mem_write_valid = 1'b1;
            tick();
            mem_write_valid = 1'b0;
        end
        @(negedge CLK);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_empty: got %b expected 1", empty); end
        tick();
    endtask

    task automatic test_coalesce();
        logic [255:0] a = rand256();
        logic [255:0] b = rand256();
        wb_req = 1'b1; wb_addr = 32'h0000_0200; wb_data = a;
        @(negedge CLK);
        checks++; if (wb_ack !== 1'b1) begin errors++; $display("FAIL coal_ack_a: got %b expected 1", wb_ack); end
        tick();
        wb_data = b; wb_addr = 32'h0000_0208;
        rd_req = 1'b1; rd_addr = 32'h0000_0200;
        @(negedge CLK);
        checks++; if (wb_ack !== 1'b1) begin errors++; $display("FAIL coal_ack_b: got %b expected 1", wb_ack); end
        checks++; if (rd_hit !== 1'b1 || rd_data !== a) begin errors++; $display("FAIL coal_same_cycle_rd: got hit %b data %h expected 1 %h", rd_hit, rd_data, a); end
        tick();
        wb_req = 1'b0;
        @(negedge CLK);
        checks++; if (rd_hit !== 1'b1 || rd_data !== b) begin errors++; $display("FAIL coal_rd_b: got hit %b data %h expected 1 %h", rd_hit, rd_data, b); end
        checks++; if (mem_write_req !== 1'b1 || mem_write_data !== b || mem_write_addr !== 32'h0000_0200) begin errors++; $display("FAIL coal_mem: got req %b addr %h data %h expected 1 00000200 %h", mem_write_req, mem_write_addr, mem_write_data, b); end
        mem_write_valid = 1'b1;
        tick();
        mem_write_valid = 1'b0;
        rd_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            checks++; if (mem_write_req !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL coal_once%0d: got req %b empty %b expected 0 1", k, mem_write_req, empty); end
            tick();
        end
    endtask

    task automatic test_locked_head();
        logic [255:0] a = rand256();
        logic [255:0] c = rand256();
        int n = 0;
        wb_req = 1'b1; wb_addr = 32'h0000_0300; wb_data = a;
        tick();
        wb_req = 1'b0;
        @(negedge CLK);
        while (mem_write_req !== 1'b1 && n < 4) begin @(negedge CLK); n++; end
        checks++; if (mem_write_req !== 1'b1 || mem_write_data !== a) begin errors++; $display("FAIL lock_head: got req %b data %h expected 1 %h", mem_write_req, mem_write_data, a); end
        wb_req = 1'b1; wb_addr = 32'h0000_0310; wb_data = c;
        #1;
        checks++; if (wb_ack !== 1'b1) begin errors++; $display("FAIL lock_ack_c: got %b expected 1", wb_ack); end
        tick();
        wb_req = 1'b0;
        rd_req = 1'b1; rd_addr = 32'h0000_031f;
        @(negedge CLK);
        checks++; if (rd_hit !== 1'b1 || rd_data !== c) begin errors++; $display("FAIL lock_rd_c: got hit %b data %h expected 1 %h", rd_hit, rd_data, c); end
        checks++; if (mem_write_data !== a || empty !== 1'b0) begin errors++; $display("FAIL lock_head_kept: got data %h empty %b expected %h 0", mem_write_data, empty, a); end
        mem_write_valid = 1'b1;
        tick();
        mem_write_valid = 1'b0;
        n = 0;
        @(negedge CLK);
        while (mem_write_req !== 1'b1 && n < 4) begin @(negedge CLK); n++; end
        checks++; if (mem_write_req !== 1'b1 || mem_write_data !== c || mem_write_addr !== 32'h0000_0300) begin errors++; $display("FAIL lock_second: got req %b addr %h data %h expected 1 00000300 %h", mem_write_req, mem_write_addr, mem_write_data, c); end
        mem_write_valid = 1'b1;
        tick();
        mem_write_valid = 1'b0;
        rd_req = 1'b0;
        @(negedge CLK);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL lock_empty: got %b expected 1", empty); end
        tick();
    endtask

    task automatic test_flush();
        int n;
        for (int i = 0; i < 2; i++) begin
            wb_req = 1'b1; wb_addr = {27'(32'h0000_0400 >> 5) + 27'(i), 5'b0}; wb_data = rand256();
            tick();
        end
        wb_req = 1'b0;
        flush = 1'b1;
        for (int j = 0; j < 2; j++) begin
            n = 0;
            @(negedge CLK);
            while (mem_write_req !== 1'b1 && n < 4) begin
                checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL flush_wait%0d: got %b expected 0", j, flush_done); end
                @(negedge CLK); n++;
            end
            checks++; if (mem_write_req !== 1'b1 || flush_done !== 1'b0) begin errors++; $display("FAIL flush_write%0d: got req %b done %b expected 1 0", j, mem_write_req, flush_done); end
            mem_write_valid = 1'b1;
            tick();
            mem_write_valid = 1'b0;
        end
        @(negedge CLK);
        checks++; if (flush_done !== 1'b1) begin errors++; $display("FAIL flush_done_after: got %b expected 1", flush_done); end
        flush = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_write();
        int n = 0;
        for (int i = 0; i < 2; i++) begin
            wb_req = 1'b1; wb_addr = {27'(32'h0000_0800 >> 5) + 27'(i), 5'b0}; wb_data = rand256();
            tick();
        end
        wb_req = 1'b0;
        @(negedge CLK);
        while (mem_write_req !== 1'b1 && n < 4) begin @(negedge CLK); n++; end
        checks++; if (mem_write_req !== 1'b1) begin errors++; $display("FAIL rstmid_write_started: got %b expected 1", mem_write_req); end
        #2 RESET = 1'b1;
        #1;
        checks++; if (mem_write_req !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL rstmid_drop: got req %b empty %b expected 0 1", mem_write_req, empty); end
        tick();
        RESET = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            checks++; if (mem_write_req !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL rstmid_quiet%0d: got req %b empty %b expected 0 1", k, mem_write_req, empty); end
            tick();
        end
    endtask

    task automatic test_random();
        entryT        q[$];
        bit           writing = 1'b0;
        logic [26:0]  pool [6];
        int           coalIdx, rdIdx, sizeBefore;
        logic         expAck, expHit;
        logic [31:0]  expAddr;
        logic [255:0] expData, expRd;
        entryT        e;
        for (int i = 0; i < 6; i++) pool[i] = 27'($urandom);
        for (int cyc = 0; cyc < 400; cyc++) begin
            wb_req  = ($urandom_range(0, 99) < 55);
            wb_addr = {pool[$urandom_range(0, 5)], 5'($urandom)};
            wb_data = rand256();
            rd_req  = ($urandom_range(0, 99) < 50);
            rd_addr = {pool[$urandom_range(0, 5)], 5'($urandom)};
            mem_write_valid = ($urandom_range(0, 99) < 40);
            flush   = ($urandom_range(0, 99) < 20);
            @(negedge CLK);
            coalIdx = -1;
            rdIdx   = -1;
            foreach (q[j]) begin
                if (q[j].tag == wb_addr[31:5] && !(writing && j == 0)) coalIdx = j;
                if (q[j].tag == rd_addr[31:5]) rdIdx = j;
            end
            expAck  = wb_req && (coalIdx >= 0 || q.size() < DEPTH);
            expHit  = rd_req && rdIdx >= 0;
            expRd   = expHit ? q[rdIdx].data : '0;
            expAddr = writing ? {q[0].tag, 5'b0} : '0;
            expData = writing ? q[0].data : '0;
            checks++; if (wb_ack !== expAck) begin errors++; $display("FAIL rnd_ack cyc %0d: got %b expected %b", cyc, wb_ack, expAck); end
            checks++; if (rd_hit !== expHit) begin errors++; $display("FAIL rnd_hit cyc %0d: got %b expected %b", cyc, rd_hit, expHit); end
            if (rd_req) begin
                checks++; if (rd_data !== expRd) begin errors++; $display("FAIL rnd_rd_data cyc %0d: got %h expected %h", cyc, rd_data, expRd); end
            end
            checks++; if (mem_write_req !== writing || mem_write_addr !== expAddr || mem_write_data !== expData) begin errors++; $display("FAIL rnd_mem cyc %0d: got req %b addr %h expected %b %h", cyc, mem_write_req, mem_write_addr, writing, expAddr); end
            checks++; if (full !== (q.size() == DEPTH) || empty !== (q.size() == 0) || flush_done !== (q.size() == 0 && !writing)) begin errors++; $display("FAIL rnd_status cyc %0d: got full %b empty %b done %b size %0d", cyc, full, empty, flush_done, q.size()); end
            sizeBefore = q.size();
            if (expAck) begin
                if (coalIdx >= 0) q[coalIdx].data = wb_data;
                else begin
                    e.tag = wb_addr[31:5];
                    e.data = wb_data;
                    q.push_back(e);
                end
            end
            if (writing && mem_write_valid) begin
                void'(q.pop_front());
                writing = 1'b0;
            end else if (!writing && sizeBefore > 0) begin
                writing = 1'b1;
            end
            tick();
        end
        clearInputs();
    endtask

    initial begin
        clearInputs();
        RESET = 1'b1;
        #1;
        test_reset();
        test_single_block();
        test_full();
        test_coalesce();
        test_locked_head();
        test_flush();
        test_reset_mid_write();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
